// File: rtl/core_run_controller_if.sv
// Handshake bundle between the top-level trigger/decode taps and core_run_controller.
// RUN_CTRL_INSTRET_EN adds the retired-instruction counter output.
interface core_run_controller_if #(
  parameter int CYCLE_CNT_W = 32
);
  logic                   first_fetch_trigger;
  logic                   run_clear;
  logic                   decode_valid;
  logic [31:0]            decode_instruction;
  logic                   core_clk_en;
  logic                   fetch_start;
  logic                   running;
  logic                   test_done;
  logic                   timeout;
  logic [CYCLE_CNT_W-1:0] cycle_count;
`ifdef RUN_CTRL_INSTRET_EN
  logic [CYCLE_CNT_W-1:0] instret_count;

  modport master (
    output first_fetch_trigger, run_clear, decode_valid, decode_instruction,
    input  core_clk_en, fetch_start, running, test_done, timeout, cycle_count, instret_count
  );
  modport slave (
    input  first_fetch_trigger, run_clear, decode_valid, decode_instruction,
    output core_clk_en, fetch_start, running, test_done, timeout, cycle_count, instret_count
  );
`else
  modport master (
    output first_fetch_trigger, run_clear, decode_valid, decode_instruction,
    input  core_clk_en, fetch_start, running, test_done, timeout, cycle_count
  );
  modport slave (
    input  first_fetch_trigger, run_clear, decode_valid, decode_instruction,
    output core_clk_en, fetch_start, running, test_done, timeout, cycle_count
  );
`endif
endinterface

// File: rtl/core_run_controller.sv
// Core run/halt controller: opens the core clock gate on trigger, stops on halt or watchdog.
// Optional RUN_CTRL_INSTRET_EN adds a saturating retired-instruction counter.
module core_run_controller #(
  parameter int          CYCLE_CNT_W     = 32,
  parameter int          WATCHDOG_CYCLES = 200,
  parameter int          DRAIN_CYCLES    = 4,
  parameter logic [31:0] HALT_INSTR      = 32'h0000006F
) (
  input logic                 clk,
  input logic                 rstn,
  core_run_controller_if.slave bus
);
  localparam int WW = $clog2(WATCHDOG_CYCLES + 1);
  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [2:0] {IDLE, START, RUN, DRAIN, HALTED, TIMEOUT} state_t;

  state_t                 r_state;
  logic                   r_clk_en, r_fetch_start, r_running, r_test_done, r_timeout;
  logic [CYCLE_CNT_W-1:0] r_cyc;
  logic [WW-1:0]          r_wd;
  logic [DW-1:0]          r_drain;
`ifdef RUN_CTRL_INSTRET_EN
  logic [CYCLE_CNT_W-1:0] r_instret;
`endif

  logic          w_halt;
  logic [WW-1:0] w_wd_next;

  assign w_halt    = bus.decode_valid && (bus.decode_instruction == HALT_INSTR);
  assign w_wd_next = bus.decode_valid ? '0 : r_wd + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= IDLE;
      r_clk_en      <= 1'b0;
      r_fetch_start <= 1'b0;
      r_running     <= 1'b0;
      r_test_done   <= 1'b0;
      r_timeout     <= 1'b0;
      r_cyc         <= '0;
      r_wd          <= '0;
      r_drain       <= '0;
`ifdef RUN_CTRL_INSTRET_EN
      r_instret     <= '0;
`endif
    end else if (bus.run_clear) begin
      r_state       <= IDLE;
      r_clk_en      <= 1'b0;
      r_fetch_start <= 1'b0;
      r_running     <= 1'b0;
      r_test_done   <= 1'b0;
      r_timeout     <= 1'b0;
      r_cyc         <= '0;
      r_wd          <= '0;
      r_drain       <= '0;
`ifdef RUN_CTRL_INSTRET_EN
      r_instret     <= '0;
`endif
    end else begin
      r_fetch_start <= 1'b0;
      // Counts every cycle the gate is open; holds at all-ones rather than wrapping.
      if (r_clk_en && (r_cyc != '1)) r_cyc <= r_cyc + 1'b1;
      case (r_state)
        IDLE: if (bus.first_fetch_trigger) begin
          r_state     <= START;
          r_clk_en    <= 1'b1;
          r_running   <= 1'b1;
          r_test_done <= 1'b0;
          r_timeout   <= 1'b0;
          r_cyc       <= '0;
`ifdef RUN_CTRL_INSTRET_EN
          r_instret   <= '0;
`endif
        end
        START: begin
          r_state       <= RUN;
          r_fetch_start <= 1'b1;
          r_wd          <= '0;
        end
        RUN: begin
`ifdef RUN_CTRL_INSTRET_EN
          if (bus.decode_valid && (r_instret != '1)) r_instret <= r_instret + 1'b1;
`endif
          // Halt is checked first so it beats a same-cycle watchdog expiry.
          if (w_halt) begin
            if (DRAIN_CYCLES == 0) begin
              r_state     <= HALTED;
              r_clk_en    <= 1'b0;
              r_running   <= 1'b0;
              r_test_done <= 1'b1;
            end else begin
              r_state <= DRAIN;
              r_drain <= DW'(DRAIN_CYCLES - 1);
            end
          end else if (w_wd_next == WW'(WATCHDOG_CYCLES)) begin
            r_state   <= TIMEOUT;
            r_clk_en  <= 1'b0;
            r_running <= 1'b0;
            r_timeout <= 1'b1;
          end else begin
            r_wd <= w_wd_next;
          end
        end
        DRAIN: begin
          if (r_drain == '0) begin
            r_state     <= HALTED;
            r_clk_en    <= 1'b0;
            r_running   <= 1'b0;
            r_test_done <= 1'b1;
          end else begin
            r_drain <= r_drain - 1'b1;
          end
        end
        HALTED, TIMEOUT: r_state <= r_state;
        default: begin
          r_state   <= IDLE;
          r_clk_en  <= 1'b0;
          r_running <= 1'b0;
        end
      endcase
    end
  end

  assign bus.core_clk_en   = r_clk_en;
  assign bus.fetch_start   = r_fetch_start;
  assign bus.running       = r_running;
  assign bus.test_done     = r_test_done;
  assign bus.timeout       = r_timeout;
  assign bus.cycle_count   = r_cyc;
`ifdef RUN_CTRL_INSTRET_EN
  assign bus.instret_count = r_instret;
`endif

endmodule

// File: tb/tb_core_run_controller.sv
// Bench for core_run_controller: directed scenarios plus random decode programs,
// each run predicted by a program-level model of the halt/watchdog rules.
module tb_core_run_controller;
  localparam int          W    = 32;
  localparam int          WD   = 200;
  localparam int          DR   = 4;
  localparam logic [31:0] HALT = 32'h0000006F;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  core_run_controller_if #(.CYCLE_CNT_W(W)) bus ();
  core_run_controller #(.CYCLE_CNT_W(W), .WATCHDOG_CYCLES(WD), .DRAIN_CYCLES(DR), .HALT_INSTR(HALT))
    dut (.clk(clk), .rstn(rstn), .bus(bus));

  int checks = 0;
  int passes = 0;

  typedef struct { logic v; logic [31:0] ins; } dec_t;
  dec_t prog[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".en"},      64'(bus.core_clk_en), 64'd0);
    chk({tag, ".fetch"},   64'(bus.fetch_start), 64'd0);
    chk({tag, ".running"}, 64'(bus.running),     64'd0);
    chk({tag, ".done"},    64'(bus.test_done),   64'd0);
    chk({tag, ".tmo"},     64'(bus.timeout),     64'd0);
    chk({tag, ".cyc"},     64'(bus.cycle_count), 64'd0);
`ifdef RUN_CTRL_INSTRET_EN
    chk({tag, ".instret"}, 64'(bus.instret_count), 64'd0);
`endif
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    if (w == HALT) w = w ^ 32'h100;
    return w;
  endfunction

  // Walk the program one RUN cycle at a time: the first valid halt ends it,
  // otherwise WD back-to-back idle decode cycles end it.
  task automatic predict(output bit is_halt, output int k, output int nvalid);
    int idle;
    dec_t e;
    idle = 0; nvalid = 0; is_halt = 0; k = 0;
    for (int c = 1; c <= 50000; c++) begin
      if (c <= prog.size()) e = prog[c-1];
      else begin e.v = 1'b0; e.ins = '0; end
      if (e.v) nvalid++;
      if (e.v && e.ins == HALT) begin is_halt = 1; k = c; return; end
      idle = e.v ? 0 : idle + 1;
      if (idle == WD) begin is_halt = 0; k = c; return; end
    end
  endtask

  task automatic start_run(input string tag);
    bus.first_fetch_trigger = 1'b1;
    step();
    bus.first_fetch_trigger = 1'b0;
    chk({tag, ".start_en"},    64'(bus.core_clk_en), 64'd1);
    chk({tag, ".start_fetch"}, 64'(bus.fetch_start), 64'd0);
    step();
    chk({tag, ".fetch_pulse"}, 64'(bus.fetch_start), 64'd1);
    chk({tag, ".run_en"},      64'(bus.core_clk_en), 64'd1);
  endtask

  task automatic drive(input int c);
    if (c <= prog.size()) begin
      bus.decode_valid       = prog[c-1].v;
      bus.decode_instruction = prog[c-1].ins;
    end else begin
      bus.decode_valid       = 1'b0;
      bus.decode_instruction = '0;
    end
  endtask

  task automatic run_prog(input string tag, input int trig_at, input int exp_cyc);
    bit is_halt;
    int k, nv;
    predict(is_halt, k, nv);
    start_run(tag);
    for (int c = 1; c <= k; c++) begin
      drive(c);
      bus.first_fetch_trigger = (c == trig_at);
      step();
      if (c < k && (c < 3 || c == trig_at || c == k - 1)) begin
        chk({tag, ".run_en"},  64'(bus.core_clk_en), 64'd1);
        chk({tag, ".run_fs"},  64'(bus.fetch_start), 64'd0);
        chk({tag, ".running"}, 64'(bus.running),     64'd1);
      end
    end
    bus.decode_valid = 1'b0;
    bus.first_fetch_trigger = 1'b0;
    if (is_halt) begin
      for (int d = 1; d <= DR; d++) begin
        chk({tag, ".drain_en"},   64'(bus.core_clk_en), 64'd1);
        chk({tag, ".drain_done"}, 64'(bus.test_done),   64'd0);
        step();
      end
      chk({tag, ".halt_en"},  64'(bus.core_clk_en), 64'd0);
      chk({tag, ".halt_run"}, 64'(bus.running),     64'd0);
      chk({tag, ".done"},     64'(bus.test_done),   64'd1);
      chk({tag, ".tmo"},      64'(bus.timeout),     64'd0);
      chk({tag, ".cyc"},      64'(bus.cycle_count), 64'(1 + k + DR));
    end else begin
      chk({tag, ".tmo_en"},   64'(bus.core_clk_en), 64'd0);
      chk({tag, ".tmo"},      64'(bus.timeout),     64'd1);
      chk({tag, ".tmo_done"}, 64'(bus.test_done),   64'd0);
      chk({tag, ".cyc"},      64'(bus.cycle_count), 64'(1 + k));
    end
`ifdef RUN_CTRL_INSTRET_EN
    chk({tag, ".instret"}, 64'(bus.instret_count), 64'(nv));
`endif
    if (exp_cyc >= 0) chk({tag, ".cyc_spec"}, 64'(bus.cycle_count), 64'(exp_cyc));
  endtask

  task automatic do_clear(input string tag);
    bus.run_clear = 1'b1;
    step();
    bus.run_clear = 1'b0;
    chk_idle(tag);
  endtask

  task automatic push_words(input int n);
    dec_t e;
    for (int i = 0; i < n; i++) begin e.v = 1'b1; e.ins = rand_word(); prog.push_back(e); end
  endtask

  task automatic push_idle(input int n);
    dec_t e;
    for (int i = 0; i < n; i++) begin e.v = 1'b0; e.ins = rand_word(); prog.push_back(e); end
  endtask

  task automatic push_halt();
    dec_t e;
    e.v = 1'b1; e.ins = HALT;
    prog.push_back(e);
  endtask

  initial begin
    rstn = 1'b0;
    bus.first_fetch_trigger = 1'b1;
    bus.run_clear = 1'b0;
    bus.decode_valid = 1'b0;
    bus.decode_instruction = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    bus.first_fetch_trigger = 1'b0;
    rstn = 1'b1;
    step();
    chk_idle("post_reset");

    // 10 ordinary words then halt: 1 START + 11 RUN + 4 DRAIN
    prog.delete(); push_words(10); push_halt();
    run_prog("halt11", -1, 16);
    bus.first_fetch_trigger = 1'b1;
    step();
    bus.first_fetch_trigger = 1'b0;
    step();
    chk("halted_trig.done", 64'(bus.test_done),   64'd1);
    chk("halted_trig.en",   64'(bus.core_clk_en), 64'd0);
    chk("halted_trig.cyc",  64'(bus.cycle_count), 64'd16);
    do_clear("clr1");

    prog.delete();
    run_prog("watchdog", -1, 201);
    do_clear("clr2");

    prog.delete(); push_idle(WD - 1); push_halt();
    run_prog("halt_at_wd", -1, 1 + WD + DR);
    do_clear("clr3");

    prog.delete(); push_idle(WD - 1); push_words(1); push_idle(WD - 1); push_halt();
    run_prog("wd_nearmiss", -1, 1 + 2 * WD + DR);
    do_clear("clr4");

    prog.delete(); push_words(5); push_halt();
    run_prog("trig_in_run", 3, 1 + 6 + DR);
    do_clear("clr5");

    // run_clear while draining
    prog.delete(); push_words(3); push_halt();
    start_run("drainclr");
    for (int c = 1; c <= 4; c++) begin drive(c); step(); end
    bus.decode_valid = 1'b0;
    step();
    chk("drainclr.en", 64'(bus.core_clk_en), 64'd1);
    do_clear("drainclr.idle");

    prog.delete(); push_words(2); push_halt();
    run_prog("restart", -1, 1 + 3 + DR);
    do_clear("clr6");

    // asynchronous reset in the middle of a run
    prog.delete(); push_words(20);
    start_run("areset");
    for (int c = 1; c <= 5; c++) begin drive(c); step(); end
    #3 rstn = 1'b0;
    #1;
    chk("areset.en",      64'(bus.core_clk_en), 64'd0);
    chk("areset.running", 64'(bus.running),     64'd0);
    chk("areset.cyc",     64'(bus.cycle_count), 64'd0);
    bus.decode_valid = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    step();
    chk_idle("areset.idle");

    for (int it = 0; it < 8; it++) begin
      int n;
      prog.delete();
      n = $urandom_range(1, 12);
      for (int j = 0; j < n; j++) begin
        if ($urandom_range(0, 5) == 0) push_idle($urandom_range(0, 240));
        else push_idle($urandom_range(0, 4));
        push_words($urandom_range(1, 4));
      end
      if ($urandom_range(0, 3) != 0) push_halt();
      run_prog($sformatf("rand%0d", it), ($urandom_range(0, 1) == 1) ? 2 : -1, -1);
      do_clear($sformatf("rclr%0d", it));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
